register_hazard_scoreboard: RTL



---
 rtl/register_access_pkg.sv | 47 ++++
 rtl/register_hazard_scoreboard_counter.sv | 29 ++
 rtl/register_hazard_scoreboard.sv | 134 +++++++++++++
 3 files changed

// File: rtl/register_access_pkg.sv
// Shared register-file encodings for the decode/register-access interlock.
// Size codes, register indices and the scoreboard FSM state type.
package register_access_pkg;

  localparam logic [2:0] SIZE_8  = 3'd0;
  localparam logic [2:0] SIZE_16 = 3'd1;
  localparam logic [2:0] SIZE_32 = 3'd2;
  localparam logic [2:0] SIZE_64 = 3'd3;

  localparam int NUM_GPR  = 8;
  localparam int NUM_SEG  = 6;
  localparam int NUM_MMX  = 8;
  localparam int NUM_REGS = NUM_GPR + NUM_SEG + NUM_MMX;

  localparam logic [2:0] GPR_EAX = 3'd0;
  localparam logic [2:0] GPR_ECX = 3'd1;
  localparam logic [2:0] GPR_EDX = 3'd2;
  localparam logic [2:0] GPR_EBX = 3'd3;
  localparam logic [2:0] GPR_ESP = 3'd4;
  localparam logic [2:0] GPR_EBP = 3'd5;
  localparam logic [2:0] GPR_ESI = 3'd6;
  localparam logic [2:0] GPR_EDI = 3'd7;

  localparam logic [2:0] SEG_ES = 3'd0;
  localparam logic [2:0] SEG_CS = 3'd1;
  localparam logic [2:0] SEG_SS = 3'd2;
  localparam logic [2:0] SEG_DS = 3'd3;
  localparam logic [2:0] SEG_FS = 3'd4;
  localparam logic [2:0] SEG_GS = 3'd5;

  localparam logic [2:0] MMX_MM0 = 3'd0;
  localparam logic [2:0] MMX_MM7 = 3'd7;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } sb_state_t;

  // 8-bit writes to numbers 4..7 are ah/ch/dh/bh, which live in eax..ebx.
  function automatic logic [2:0] gpr_wb_target(input logic [2:0] number,
                                               input logic [2:0] size);
    if (size == SIZE_8 && number[2])
      return {1'b0, number[1:0]};
    return number;
  endfunction

endpackage

// File: rtl/register_hazard_scoreboard_counter.sv
// Saturating pending-write counter for one architectural register.
// Simultaneous inc and dec cancel; clr wins over both.
module scoreboard_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic full
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && !dec && !full)
      cnt <= cnt + 1'b1;
    else if (dec && !inc && !zero)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
  assign full = (cnt == {CNT_W{1'b1}});

endmodule

// File: rtl/register_hazard_scoreboard.sv
// RAW/WAW interlock between decode and register access for GPR/segment/MMX.
// Optional sticky underflow flag when built with REG_SCOREBOARD_ERR_EN.
//
// state   | meaning
// ST_RUN  | handshake passes unless a hazard exists
// ST_HOLD | post-flush quiet period, no issue, writebacks dropped
module register_hazard_scoreboard
  import register_access_pkg::*;
#(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       d_valid,
  output logic       d_ready,
  output logic       r_valid,
  input  logic       r_ready,
  input  logic [7:0] d_src_gpr,
  input  logic [5:0] d_src_seg,
  input  logic [7:0] d_src_mmx,
  input  logic [7:0] d_dst_gpr,
  input  logic [5:0] d_dst_seg,
  input  logic [7:0] d_dst_mmx,
  input  logic [2:0] wb_reg_number,
  input  logic       wb_reg_en,
  input  logic [2:0] wb_reg_size,
  input  logic [2:0] wb_seg_number,
  input  logic       wb_seg_en,
  input  logic [2:0] wb_mmx_number,
  input  logic       wb_mmx_en,
  output logic       hazard,
  output logic       busy
`ifdef REG_SCOREBOARD_ERR_EN
  , output logic     err_underflow
`endif
);

  localparam int HOLD_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(FLUSH_CYCLES - 1);

  sb_state_t           state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                run;
  logic                go;
  logic                issue;
  logic [2:0]          gpr_tgt;

  logic [NUM_GPR-1:0]  dec_gpr;
  logic [NUM_SEG-1:0]  dec_seg;
  logic [NUM_MMX-1:0]  dec_mmx;
  logic [NUM_REGS-1:0] src_all, dst_all, inc_all, dec_all, zero_all, full_all;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (flush) state_nxt = ST_HOLD;
      ST_HOLD: if (!flush && hold_cnt == '0) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    run = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset)
      hold_cnt <= '0;
    else if (flush)
      hold_cnt <= HOLD_LOAD;
    else if (state == ST_HOLD && hold_cnt != '0)
      hold_cnt <= hold_cnt - 1'b1;
  end

  assign src_all = {d_src_mmx, d_src_seg, d_src_gpr};
  assign dst_all = {d_dst_mmx, d_dst_seg, d_dst_gpr};

  // Full counters block new writers so they can never wrap.
  assign hazard  = d_valid & ((|(src_all & ~zero_all)) | (|(dst_all & full_all)));
  assign go      = run & ~hazard;
  assign r_valid = d_valid & go;
  assign d_ready = r_ready & go;
  assign issue   = d_valid & d_ready;

  assign gpr_tgt = gpr_wb_target(wb_reg_number, wb_reg_size);

  always_comb begin
    dec_gpr = '0;
    dec_seg = '0;
    dec_mmx = '0;
    for (int i = 0; i < NUM_GPR; i++)
      dec_gpr[i] = wb_reg_en && (gpr_tgt == 3'(i));
    for (int i = 0; i < NUM_SEG; i++)
      dec_seg[i] = wb_seg_en && (wb_seg_number == 3'(i));
    for (int i = 0; i < NUM_MMX; i++)
      dec_mmx[i] = wb_mmx_en && (wb_mmx_number == 3'(i));
  end

  assign inc_all = dst_all & {NUM_REGS{issue & ~flush}};
  assign dec_all = {dec_mmx, dec_seg, dec_gpr} & {NUM_REGS{run & ~flush}};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    scoreboard_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (inc_all[g]),
      .dec  (dec_all[g]),
      .clr  (flush),
      .zero (zero_all[g]),
      .full (full_all[g])
    );
  end

  assign busy = |(~zero_all);

`ifdef REG_SCOREBOARD_ERR_EN
  always_ff @(posedge clk) begin
    if (reset)
      err_underflow <= 1'b0;
    else if (|(dec_all & zero_all))
      err_underflow <= 1'b1;
  end
`endif

endmodule
